// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// It sequences fetch, decode, execute, memory and write-back over one shared
// instruction/data memory, using the MemReady handshake. It also keeps a
// retired-instruction counter and a sticky fault state.
// Ports:
//   clk, reset (async active-low)  - clock and reset
//   OP, Funct                      - instruction fields from the IR
//   MemReady                       - memory access completes this cycle
//   PCWrite..PCSource, ALUOp       - datapath control strobes and mux selects
//   Fault                          - illegal opcode or memory-wait timeout (sticky)
//   InstrCount                     - retired instruction count (wraps)
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int WAIT_MAX    = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic [5:0]             Funct,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             MemtoReg,
  output logic [1:0]             RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   Fault,
  output logic [CNT_WIDTH-1:0]   InstrCount
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(3'b001);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(3'b010);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = ALUOP_WIDTH'(3'b011);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(3'b100);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                retire;
  logic                wait_state;
  logic                timeout_hit;
  logic [WAIT_W-1:0]   wait_cnt;

  // Only FETCH, MEM_RD and MEM_WR stall on memory.
  assign wait_state  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout_hit = (WAIT_MAX > 0) && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  // Next-state and retire decode; in wait states MemReady wins over the timeout.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (MemReady)         next_state = S_DECODE;
        else if (timeout_hit) next_state = S_FAULT;
        else                  next_state = S_FETCH;
      end
      S_DECODE: begin
        case (OP)
          6'h00:               next_state = (Funct == 6'h08) ? S_JR : S_EXEC_R;
          6'h08, 6'h0d, 6'h0f: next_state = S_EXEC_I;
          6'h23, 6'h2b:        next_state = S_MEM_ADDR;
          6'h04, 6'h05:        next_state = S_BRANCH;
          6'h02:               next_state = S_JUMP;
          6'h03:               next_state = S_JAL;
          default:             next_state = S_FAULT;
        endcase
      end
      S_EXEC_R: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_MEM_ADDR: begin
        if (OP == 6'h23)      next_state = S_MEM_RD;
        else if (OP == 6'h2b) next_state = S_MEM_WR;
        else                  next_state = S_FAULT;
      end
      S_MEM_RD: begin
        if (MemReady)         next_state = S_WB_MEM;
        else if (timeout_hit) next_state = S_FAULT;
        else                  next_state = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (MemReady) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (timeout_hit) begin
          next_state = S_FAULT;
        end else begin
          next_state = S_MEM_WR;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase
  end

  // State register, retire counter and memory-wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      InstrCount <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= next_state;
      if (retire) InstrCount <= InstrCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else        InstrCount <= InstrCount;
      // Any state change clears the counter, so each wait state starts from zero.
      if (next_state != state)         wait_cnt <= '0;
      else if (wait_state && !MemReady) wait_cnt <= wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
      else                              wait_cnt <= wait_cnt;
    end
  end

  // Control outputs decoded from the state register; PCWrite/IRWrite follow MemReady in FETCH.
  always_comb begin
    PCWrite  = 1'b0;
    BranchEQ = 1'b0;
    BranchNE = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 2'b00;
    RegDst   = 2'b00;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = ALU_ADD;
    Fault    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == 6'h0d)      ALUOp = ALU_OR;
        else if (OP == 6'h0f) ALUOp = ALU_LUI;
        else                  ALUOp = ALU_ADD;
      end
      S_WB_I: RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        BranchEQ = (OP == 6'h04);
        BranchNE = (OP == 6'h05);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      S_FAULT: Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (WAIT_MAX = 5, 3-bit ALUOp, 32-bit count).
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic        MemReady;
  logic        PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  MemtoReg, RegDst;
  logic        RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        Fault;
  logic [31:0] InstrCount;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(.ALUOP_WIDTH(3), .WAIT_MAX(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .Fault(Fault), .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word: {PCWrite,BranchEQ,BranchNE,IorD,MemRead,MemWrite,IRWrite,
  //                       MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,Fault}
  logic [20:0] ctl;
  assign ctl = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, Fault};

  //                         pw eq ne id mr mw ir  m2r    rdst   rw sa  sb     pcs    aluop   f
  localparam logic [20:0] C_FETCH_R = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_FETCH_W = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_EXEC_R  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b00,3'b010,1'b0};
  localparam logic [20:0] C_WB_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_EXI_OR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,3'b011,1'b0};
  localparam logic [20:0] C_EXI_LUI = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,3'b100,1'b0};
  localparam logic [20:0] C_WB_I    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_MADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_MEM_RD  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_WB_MEM  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_MEM_WR  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [20:0] C_BR_NE   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b01,3'b001,1'b0};
  localparam logic [20:0] C_BR_EQ   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b01,3'b001,1'b0};
  localparam logic [20:0] C_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0};
  localparam logic [20:0] C_JAL     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,2'b10,3'b000,1'b0};
  localparam logic [20:0] C_JR      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b11,3'b000,1'b0};
  localparam logic [20:0] C_FAULT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; check the control word, then move to the next falling edge.
  task automatic step(input string tag, input logic [20:0] exp);
    #1;
    chk(tag, {11'd0, ctl}, {11'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; OP = 6'h00; Funct = 6'h20; MemReady = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_ctl", {11'd0, ctl}, {11'd0, C_FETCH_R});
    chk("reset_cnt", InstrCount, 32'd0);
    chk("reset_fault", {31'd0, Fault}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // R-type add: 4 cycles
    step("r_fetch", C_FETCH_R);
    step("r_decode", C_DECODE);
    step("r_exec", C_EXEC_R);
    step("r_wb", C_WB_R);
    #1 chk("r_cnt", InstrCount, 32'd1);

    // LW with 3 wait cycles in MEM_RD: 8 cycles
    OP = 6'h23;
    step("lw_fetch", C_FETCH_R);
    step("lw_decode", C_DECODE);
    step("lw_addr", C_MADDR);
    MemReady = 1'b0;
    step("lw_rd_w1", C_MEM_RD);
    step("lw_rd_w2", C_MEM_RD);
    step("lw_rd_w3", C_MEM_RD);
    MemReady = 1'b1;
    step("lw_rd_go", C_MEM_RD);
    step("lw_wb", C_WB_MEM);
    #1 chk("lw_cnt", InstrCount, 32'd2);

    // BNE then BEQ
    OP = 6'h05;
    step("bne_fetch", C_FETCH_R);
    step("bne_decode", C_DECODE);
    step("bne_br", C_BR_NE);
    OP = 6'h04;
    step("beq_fetch", C_FETCH_R);
    step("beq_decode", C_DECODE);
    step("beq_br", C_BR_EQ);

    // JAL then JR
    OP = 6'h03;
    step("jal_fetch", C_FETCH_R);
    step("jal_decode", C_DECODE);
    step("jal_jal", C_JAL);
    OP = 6'h00; Funct = 6'h08;
    step("jr_fetch", C_FETCH_R);
    step("jr_decode", C_DECODE);
    step("jr_jr", C_JR);
    #1 chk("jr_cnt", InstrCount, 32'd6);

    // ORI, SW, J
    OP = 6'h0d;
    step("ori_fetch", C_FETCH_R);
    step("ori_decode", C_DECODE);
    step("ori_exec", C_EXI_OR);
    step("ori_wb", C_WB_I);
    OP = 6'h2b;
    step("sw_fetch", C_FETCH_R);
    step("sw_decode", C_DECODE);
    step("sw_addr", C_MADDR);
    step("sw_wr", C_MEM_WR);
    OP = 6'h02;
    step("j_fetch", C_FETCH_R);
    step("j_decode", C_DECODE);
    step("j_jump", C_JUMP);
    #1 chk("j_cnt", InstrCount, 32'd9);

    // Illegal opcode: sticky fault, count unchanged
    OP = 6'h3f;
    step("ill_fetch", C_FETCH_R);
    step("ill_decode", C_DECODE);
    step("ill_fault1", C_FAULT);
    OP = 6'h00; Funct = 6'h20;
    step("ill_fault2", C_FAULT);
    step("ill_fault3", C_FAULT);
    #1 chk("ill_cnt", InstrCount, 32'd9);

    // Fetch timeout: 5 stalled cycles lead to FAULT
    do_reset();
    MemReady = 1'b0;
    #1 chk("to_cnt_rst", InstrCount, 32'd0);
    for (int i = 0; i < 5; i++) step("to_fetch_wait", C_FETCH_W);
    step("to_fault", C_FAULT);

    // MemReady on the 5th cycle beats the timeout; then LUI retires
    do_reset();
    MemReady = 1'b0; OP = 6'h0f;
    for (int i = 0; i < 4; i++) step("pri_fetch_wait", C_FETCH_W);
    MemReady = 1'b1;
    step("pri_fetch_go", C_FETCH_R);
    step("pri_decode", C_DECODE);
    step("lui_exec", C_EXI_LUI);
    step("lui_wb", C_WB_I);
    #1 chk("lui_cnt", InstrCount, 32'd1);

    // Reset asserted in MEM_WR drops MemWrite at once
    OP = 6'h2b;
    step("rst_fetch", C_FETCH_R);
    step("rst_decode", C_DECODE);
    step("rst_addr", C_MADDR);
    MemReady = 1'b0;
    #1 chk("rst_memwrite_on", {31'd0, MemWrite}, 32'd1);
    #1 reset = 1'b0;
    #1 chk("rst_memwrite_off", {31'd0, MemWrite}, 32'd0);
    chk("rst_ctl", {11'd0, ctl}, {11'd0, C_FETCH_W});
    chk("rst_cnt", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b1; OP = 6'h00; Funct = 6'h20;
    step("post_fetch", C_FETCH_R);
    step("post_decode", C_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
